// File: rtl/mips_instr_encoder_if.sv
// Field-bundle handshake between the loader (master) and the instruction encoder (slave).
interface mips_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_last,
        output in_ready
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// Assembles decoded R/lw/sw/beq field bundles into 32-bit MIPS words and writes them to
// instruction memory at sequential word addresses.
module mips_instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    mips_instr_encoder_if.slave in_bus,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_ack,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                done,
    output logic                err
);

    localparam int unsigned       CntW     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic                last_q, last_d;

    logic                accept;
    logic                funct_ok;
    logic                illegal;
    logic [31:0]         word;

    // clear blocks acceptance in the same cycle so a restart never swallows a bundle
    assign in_bus.in_ready = (state_q == StIdle) && !full_q && !clear;
    assign accept          = in_bus.in_valid && in_bus.in_ready;

    // Field-to-word assembly and funct legality check
    always_comb begin
        word     = '0;
        funct_ok = 1'b0;
        case (in_bus.in_funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                               funct_ok = 1'b0;
        endcase
        unique case (in_bus.in_kind)
            2'b00: word = {6'b000000, in_bus.in_rs, in_bus.in_rt, in_bus.in_rd, 5'b00000,
                           in_bus.in_funct};
            2'b01: word = {6'b100011, in_bus.in_rs, in_bus.in_rt, in_bus.in_imm};
            2'b10: word = {6'b101011, in_bus.in_rs, in_bus.in_rt, in_bus.in_imm};
            2'b11: word = {6'b000100, in_bus.in_rs, in_bus.in_rt, in_bus.in_imm};
            default: word = '0;
        endcase
        illegal = (in_bus.in_kind == 2'b00) && !funct_ok;
    end

    // Next-state logic for the accept/write/done sequencing
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        last_d  = last_q;
        if (clear) begin
            // Any in-flight write is dropped without counting
            state_d = StIdle;
            addr_d  = BaseAddr;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (illegal) begin
                            err_d = 1'b1;
                            if (in_bus.in_last) state_d = StDone;
                        end else begin
                            wdata_d = word;
                            last_d  = in_bus.in_last;
                            state_d = StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (mem_ack) begin
                        count_d = count_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        full_d  = ((count_q + 1'b1) == DepthCnt);
                        state_d = last_q ? StDone : StIdle;
                    end
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= BaseAddr;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // Registered outputs; write strobe is simply "in WRITE" so addr/wdata stay stable until ack
    always_comb begin
        mem_we    = (state_q == StWrite);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        count     = count_q;
        full      = full_q;
        done      = (state_q == StDone);
        err       = err_q;
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: table-driven bundles, scoreboard on memory writes.
module tb_mips_instr_encoder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic mem_we;
    logic mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [ADDR_W:0] count;
    logic full;
    logic done;
    logic err;

    always #5 clk = ~clk;

    mips_instr_encoder_if bus ();

    mips_instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_bus    (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .count     (count),
        .full      (full),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic        last;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int ack_lat = 0;
    int exp_cnt = 0;
    logic [ADDR_W-1:0] exp_addr = '0;

    vec_t tbl_a[5];
    vec_t tbl_b[4];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [5:0] f,
                                input logic [15:0] imm, input logic last, input logic legal,
                                input logic [31:0] w);
        vec_t r;
        r.kind = k; r.rs = rs; r.rt = rt; r.rd = rd; r.funct = f;
        r.imm = imm; r.last = last; r.legal = legal; r.word = w;
        return r;
    endfunction

    // Offer one bundle; push the expected write when push is set
    task automatic send(input vec_t x, input bit push);
        int t = 0;
        @(negedge clk);
        bus.in_kind = x.kind; bus.in_rs = x.rs; bus.in_rt = x.rt; bus.in_rd = x.rd;
        bus.in_funct = x.funct; bus.in_imm = x.imm; bus.in_last = x.last; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: in_ready stayed %b for 50 cycles, required 1",
                     bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            if (push) begin
                sb.push_back('{exp_addr, x.word});
                exp_addr++;
            end
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_quiet();
        int t = 0;
        @(negedge clk);
        while ((mem_we === 1'b1 || sb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: mem_we=%b pending=%0d, required 0/0", mem_we, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_cnt  = 0;
        exp_addr = '0;
    endtask

    task automatic check_cleared();
        @(negedge clk);
        check("clr_count", count, 0);
        check("clr_addr", mem_addr, 0);
        check("clr_ready", bus.in_ready, 1);
        check("clr_full", full, 0);
        check("clr_err", err, 0);
        check("clr_done", done, 0);
    endtask

    // Memory model: ack after ack_lat waiting cycles, score writes, check hold stability
    initial begin
        int wcnt;
        bit prev_ack;
        exp_t e;
        logic [ADDR_W-1:0] held_addr;
        logic [31:0] held_wdata;
        mem_ack = 1'b0; wcnt = 0; prev_ack = 0;
        held_addr = '0; held_wdata = '0;
        forever begin
            @(negedge clk);
            if (prev_ack) begin
                check("count_after_ack", count, exp_cnt);
                check("we_drop_after_ack", mem_we, 0);
                prev_ack = 0;
            end
            if (mem_we === 1'b1) begin
                if (wcnt > 0) begin
                    check("hold_addr", mem_addr, held_addr);
                    check("hold_wdata", mem_wdata, held_wdata);
                    check("hold_ready", bus.in_ready, 0);
                end else begin
                    held_addr  = mem_addr;
                    held_wdata = mem_wdata;
                end
                if (wcnt >= ack_lat) begin
                    mem_ack = 1'b1;
                    wcnt = 0;
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, required none",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.word);
                    end
                    exp_cnt++;
                    prev_ack = 1;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl_a[0] = mk(2'b01, 5'd16, 5'd9, 5'd0, 6'd0, 16'h0004, 1'b0, 1'b1, 32'h8E090004);
        tbl_a[1] = mk(2'b00, 5'd9, 5'd10, 5'd8, 6'b100000, 16'h0, 1'b0, 1'b1, 32'h012A4020);
        tbl_a[2] = mk(2'b00, 5'd1, 5'd2, 5'd3, 6'b000111, 16'h0, 1'b0, 1'b0, 32'h0);
        tbl_a[3] = mk(2'b10, 5'd16, 5'd9, 5'd0, 6'd0, 16'h0008, 1'b0, 1'b1, 32'hAE090008);
        tbl_a[4] = mk(2'b00, 5'd1, 5'd2, 5'd3, 6'b100010, 16'h0, 1'b0, 1'b1, 32'h00221822);
        tbl_b[0] = mk(2'b00, 5'd4, 5'd5, 5'd6, 6'b100100, 16'h0, 1'b0, 1'b1, 32'h00853024);
        tbl_b[1] = mk(2'b00, 5'd31, 5'd31, 5'd31, 6'b100101, 16'h0, 1'b0, 1'b1, 32'h03FFF825);
        tbl_b[2] = mk(2'b00, 5'd0, 5'd7, 5'd2, 6'b101010, 16'h0, 1'b0, 1'b1, 32'h0007102A);
        tbl_b[3] = mk(2'b01, 5'd0, 5'd0, 5'd31, 6'h3F, 16'hABCD, 1'b0, 1'b1, 32'h8C00ABCD);

        rst_n = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
        bus.in_funct = '0; bus.in_imm = '0; bus.in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", bus.in_ready, 1);

        // Table A: mixed kinds with one illegal funct, fills DEPTH=4
        for (int i = 0; i < 5; i++) begin
            send(tbl_a[i], tbl_a[i].legal);
            if (!tbl_a[i].legal) begin
                @(negedge clk);
                check("illegal_err", err, 1);
                check("illegal_no_we", mem_we, 0);
                check("illegal_count", count, exp_cnt);
            end
        end
        wait_quiet();
        check("a_count", count, 4);
        check("a_full", full, 1);
        check("a_ready_full", bus.in_ready, 0);
        check("a_err", err, 1);
        // Bundle offered while full must wait, not be written
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("full_no_we", mem_we, 0);
        check("full_count", count, 4);
        bus.in_valid = 1'b0;
        do_clear();
        check_cleared();

        // Table B: remaining funct codes and I-type ignoring rd/funct
        for (int i = 0; i < 4; i++) send(tbl_b[i], 1'b1);
        wait_quiet();
        check("b_count", count, 4);
        check("b_full", full, 1);
        do_clear();
        check_cleared();

        // Ack held off 5 cycles, then beq with in_last
        ack_lat = 5;
        send(tbl_a[1], 1'b1);
        wait_quiet();
        ack_lat = 0;
        v = mk(2'b11, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 1'b1, 1'b1, 32'h1109FFFF);
        send(v, 1'b1);
        wait_quiet();
        check("beq_done", done, 1);
        check("beq_ready", bus.in_ready, 0);
        check("beq_count", count, 2);
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("done_no_we", mem_we, 0);
        check("done_hold", done, 1);
        bus.in_valid = 1'b0;
        do_clear();
        check_cleared();

        // clear and in_valid together: bundle must not be accepted
        @(negedge clk);
        bus.in_kind = 2'b01; bus.in_valid = 1'b1; clear = 1'b1;
        #1 check("clr_valid_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 clear = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("clr_valid_no_we", mem_we, 0);

        // clear during WRITE aborts the word
        ack_lat = 1000;
        send(tbl_a[0], 1'b0);
        repeat (3) @(negedge clk);
        check("abort_we_high", mem_we, 1);
        do_clear();
        @(negedge clk);
        check("abort_we_low", mem_we, 0);
        check("abort_count", count, 0);
        ack_lat = 0;
        send(tbl_a[4], 1'b1);
        wait_quiet();
        check("post_abort_count", count, 1);

        // Illegal bundle carrying in_last goes to DONE without writing
        v = mk(2'b00, 5'd1, 5'd1, 5'd1, 6'b111111, 16'h0, 1'b1, 1'b0, 32'h0);
        send(v, 1'b0);
        @(negedge clk);
        check("ill_last_done", done, 1);
        check("ill_last_err", err, 1);
        check("ill_last_no_we", mem_we, 0);
        check("ill_last_count", count, 1);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
